// File: rtl/axis_log_decoder.sv
// Byte-stream receiver for the change-detection logger: reassembles samples, checks tlast framing
// and keeps status counters. Define LOG_DECODER_CHANGE_CHECK_EN to flag repeated change fields.
module axis_log_decoder #(
    parameter int unsigned FIFO_WIDTH  = 32,
    parameter int unsigned PACKET_SIZE = 8,
    parameter int unsigned SIG_WIDTH   = 16,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            s_tvalid,
    output logic                            s_tready,
    input  logic                            s_tlast,
    input  logic                            s_tkeep,
    input  logic [7:0]                      s_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast,
    output logic [SIG_WIDTH-1:0]            m_change,
    output logic [FIFO_WIDTH-SIG_WIDTH-1:0] m_ignore,
    output logic                            err_short_o,
    output logic                            err_long_o,
    output logic                            err_change_o,
    output logic [CNT_WIDTH-1:0]            samples_o,
    output logic [CNT_WIDTH-1:0]            errors_o
);

    localparam int unsigned BYTES  = FIFO_WIDTH / 8;
    localparam int unsigned BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned SIDX_W = $clog2(PACKET_SIZE);
    localparam int unsigned BUF_W  = FIFO_WIDTH - 8;
    localparam logic [BIDX_W-1:0] LAST_BYTE   = BIDX_W'(BYTES - 1);
    localparam logic [SIDX_W-1:0] LAST_SAMPLE = SIDX_W'(PACKET_SIZE - 1);

    typedef enum logic [0:0] {StRecv, StDrop} state_e;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [BIDX_W-1:0]       r_bidx;
    logic [SIDX_W-1:0]       r_sidx;
    logic [BUF_W-1:0]        r_buf;
    logic                    r_m_tvalid;
    logic                    r_m_tlast;
    logic [FIFO_WIDTH-1:0]   r_m_data;
    logic                    r_err_short;
    logic                    r_err_long;
    logic                    r_err_change;
    logic [CNT_WIDTH-1:0]    r_samples;
    logic [CNT_WIDTH-1:0]    r_errors;

    logic                    w_ready;
    logic                    w_xfer;
    logic                    w_final_byte;
    logic                    w_last_sample;
    logic                    w_load;
    logic                    w_short;
    logic                    w_long;
    logic                    w_change_err;
    logic [FIFO_WIDTH-1:0]   w_sample;
    logic [1:0]              w_err_inc;
    logic [CNT_WIDTH:0]      w_err_sum;

    // The final byte goes straight into the output register, so the buffer only holds the rest.
    assign w_sample = {s_tdata, r_buf};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= StRecv;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StRecv:  if (w_long) w_state_next = StDrop;
            StDrop:  if (w_xfer && s_tlast) w_state_next = StRecv;
            default: w_state_next = StRecv;
        endcase
    end

    always_comb begin
        w_ready       = reset_n && ((r_state == StDrop) || !r_m_tvalid || m_tready);
        w_xfer        = s_tvalid && w_ready;
        w_final_byte  = s_tkeep && (r_bidx == LAST_BYTE);
        w_last_sample = (r_sidx == LAST_SAMPLE);
        w_load        = 1'b0;
        w_short       = 1'b0;
        w_long        = 1'b0;
        if (r_state == StRecv && w_xfer) begin
            if (s_tlast) begin
                if (w_final_byte && w_last_sample) begin
                    w_load = 1'b1;
                end else begin
                    w_short = 1'b1;
                end
            end else if (w_final_byte) begin
                w_load = 1'b1;
                w_long = w_last_sample;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_bidx <= '0;
            r_sidx <= '0;
            r_buf  <= '0;
        end else if (r_state == StRecv && w_xfer) begin
            if (s_tlast || w_final_byte) begin
                r_bidx <= '0;
                r_sidx <= (s_tlast || w_last_sample) ? '0 : r_sidx + 1'b1;
            end else if (s_tkeep) begin
                r_bidx               <= r_bidx + 1'b1;
                r_buf[8*r_bidx +: 8] <= s_tdata;
            end
        end
    end

    // Loads only happen while ready, so a held sample is never overwritten before it drains.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_data   <= '0;
        end else if (w_load) begin
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= w_last_sample;
            r_m_data   <= w_sample;
        end else if (r_m_tvalid && m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

`ifdef LOG_DECODER_CHANGE_CHECK_EN
    logic [SIG_WIDTH-1:0] r_last_change;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_last_change <= '1;
        end else if (w_load) begin
            r_last_change <= w_sample[SIG_WIDTH-1:0];
        end
    end

    assign w_change_err = w_load && (w_sample[SIG_WIDTH-1:0] == r_last_change);
`else
    assign w_change_err = 1'b0;
`endif

    assign w_err_inc = 2'(w_short) + 2'(w_long) + 2'(w_change_err);
    assign w_err_sum = {1'b0, r_errors} + {{(CNT_WIDTH - 1){1'b0}}, w_err_inc};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;
            r_err_change <= 1'b0;
            r_samples    <= '0;
            r_errors     <= '0;
        end else begin
            r_err_short  <= w_short;
            r_err_long   <= w_long;
            r_err_change <= w_change_err;
            r_errors     <= w_err_sum[CNT_WIDTH] ? '1 : w_err_sum[CNT_WIDTH-1:0];
            if (r_m_tvalid && m_tready && (r_samples != '1)) begin
                r_samples <= r_samples + 1'b1;
            end
        end
    end

    assign s_tready     = w_ready;
    assign m_tvalid     = r_m_tvalid;
    assign m_tlast      = r_m_tlast;
    assign m_change     = r_m_data[SIG_WIDTH-1:0];
    assign m_ignore     = r_m_data[FIFO_WIDTH-1:SIG_WIDTH];
    assign err_short_o  = r_err_short;
    assign err_long_o   = r_err_long;
    assign err_change_o = r_err_change;
    assign samples_o    = r_samples;
    assign errors_o     = r_errors;

endmodule

// File: tb/tb_axis_log_decoder.sv
// Self-checking bench for axis_log_decoder: directed and randomized byte streams against a
// byte-queue reference model; honours LOG_DECODER_CHANGE_CHECK_EN like the design.
module tb_axis_log_decoder;

    localparam int unsigned FW    = 32;
    localparam int unsigned PS    = 8;
    localparam int unsigned SW    = 16;
    localparam int unsigned CW    = 16;
    localparam int unsigned BYTES = FW / 8;

    typedef struct packed {
        logic [FW-1:0] data;
        logic          last;
    } samp_t;

    typedef struct packed {
        logic [7:0] d;
        logic       k;
        logic       l;
    } tx_t;

    logic clock = 1'b0;
    logic reset_n;
    logic s_tvalid, s_tready, s_tlast, s_tkeep;
    logic [7:0] s_tdata;
    logic m_tvalid, m_tready, m_tlast;
    logic [SW-1:0] m_change;
    logic [FW-SW-1:0] m_ignore;
    logic err_short_o, err_long_o, err_change_o;
    logic [CW-1:0] samples_o, errors_o;

    int n_cmp = 0;
    int n_bad = 0;
    int rdy_mode = 0;
    bit gap_en = 1'b1;

    samp_t exp_q[$];
    samp_t rx_log[$];
    tx_t   tx_q[$];
    logic [7:0] md_cur[$];
    bit md_drop;
    int md_nsamp;
    logic [SW-1:0] md_last_change;
    int exp_short, exp_long, exp_change, exp_samples;
    int obs_short, obs_long, obs_change;

    axis_log_decoder #(
        .FIFO_WIDTH (FW),
        .PACKET_SIZE(PS),
        .SIG_WIDTH  (SW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tlast     (s_tlast),
        .s_tkeep     (s_tkeep),
        .s_tdata     (s_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .m_change    (m_change),
        .m_ignore    (m_ignore),
        .err_short_o (err_short_o),
        .err_long_o  (err_long_o),
        .err_change_o(err_change_o),
        .samples_o   (samples_o),
        .errors_o    (errors_o)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: collect kept bytes, frame samples by count, track packet position.
    task automatic emit(input logic [FW-1:0] s, input logic last);
        exp_q.push_back('{data: s, last: last});
        exp_samples++;
`ifdef LOG_DECODER_CHANGE_CHECK_EN
        if (s[SW-1:0] == md_last_change) exp_change++;
        md_last_change = s[SW-1:0];
`endif
    endtask

    task automatic model_byte(input logic [7:0] d, input logic k, input logic l);
        logic [FW-1:0] s;
        if (md_drop) begin
            if (l) md_drop = 1'b0;
            return;
        end
        if (k) md_cur.push_back(d);
        if (md_cur.size() == BYTES) begin
            s = '0;
            for (int i = 0; i < BYTES; i++) s[8*i +: 8] = md_cur[i];
            md_cur.delete();
            if (l) begin
                if (md_nsamp == PS - 1) emit(s, 1'b1);
                else exp_short++;
                md_nsamp = 0;
            end else if (md_nsamp == PS - 1) begin
                emit(s, 1'b1);
                exp_long++;
                md_drop  = 1'b1;
                md_nsamp = 0;
            end else begin
                emit(s, 1'b0);
                md_nsamp++;
            end
        end else if (l) begin
            exp_short++;
            md_cur.delete();
            md_nsamp = 0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        md_cur.delete();
        md_drop        = 1'b0;
        md_nsamp       = 0;
        md_last_change = '1;
        exp_short      = 0;
        exp_long       = 0;
        exp_change     = 0;
        exp_samples    = 0;
        obs_short      = 0;
        obs_long       = 0;
        obs_change     = 0;
    endtask

    // Output monitor: scoreboard on handshakes, stability while stalled, error pulse counts.
    initial begin
        bit prev_hold = 1'b0;
        logic [FW-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        samp_t e;
        forever begin
            @(negedge clock);
            if (err_short_o === 1'b1) obs_short++;
            if (err_long_o === 1'b1) obs_long++;
            if (err_change_o === 1'b1) obs_change++;
            if (reset_n && prev_hold) begin
                check("hold_m_tvalid", m_tvalid, 1'b1);
                check("hold_data", {m_ignore, m_change}, prev_data);
                check("hold_m_tlast", m_tlast, prev_last);
            end
            if (reset_n && m_tvalid && m_tready) begin
                check("sample_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("m_change", m_change, e.data[SW-1:0]);
                    check("m_ignore", m_ignore, e.data[FW-1:SW]);
                    check("m_tlast", m_tlast, e.last);
                    rx_log.push_back('{data: {m_ignore, m_change}, last: m_tlast});
                end
            end
            prev_hold = reset_n && m_tvalid && !m_tready;
            prev_data = {m_ignore, m_change};
            prev_last = m_tlast;
        end
    end

    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = 1'($urandom_range(0, 1));
                default: m_tready = 1'b0;
            endcase
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] d, input logic k, input logic l);
        int guard = 0;
        if (gap_en) repeat ($urandom_range(0, 1)) begin @(posedge clock); #1; end
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        @(negedge clock);
        while (!s_tready && guard < 300) begin
            guard++;
            @(negedge clock);
        end
        check("s_tready_wait", s_tready, 1'b1);
        @(posedge clock);
        #1;
        s_tvalid = 1'b0;
        model_byte(d, k, l);
    endtask

    task automatic send_all();
        tx_t t;
        while (tx_q.size() != 0) begin
            t = tx_q.pop_front();
            send_byte(t.d, t.k, t.l);
        end
    endtask

    task automatic push_ramp(input int n, input int last_at);
        for (int i = 0; i < n; i++) tx_q.push_back('{d: 8'(i), k: 1'b1, l: (i == last_at)});
    endtask

    task automatic wait_drain(input string tag);
        int g = 0;
        while (exp_q.size() != 0 && g < 2000) begin
            @(negedge clock);
            g++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        repeat (4) @(negedge clock);
    endtask

    task automatic end_check(input string tag);
        wait_drain(tag);
        check({tag, "_err_short"}, obs_short, exp_short);
        check({tag, "_err_long"}, obs_long, exp_long);
        check({tag, "_err_change"}, obs_change, exp_change);
        check({tag, "_samples_o"}, samples_o, CW'(exp_samples));
        check({tag, "_errors_o"}, errors_o, CW'(exp_short + exp_long + exp_change));
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        model_reset();
        rx_log.delete();
        @(negedge clock);
        check({tag, "_rst_s_tready"}, s_tready, 1'b0);
        check({tag, "_rst_m_tvalid"}, m_tvalid, 1'b0);
        check({tag, "_rst_m_tlast"}, m_tlast, 1'b0);
        check({tag, "_rst_data"}, {m_ignore, m_change}, 0);
        check({tag, "_rst_errs"}, {err_short_o, err_long_o, err_change_o}, 0);
        check({tag, "_rst_samples_o"}, samples_o, 0);
        check({tag, "_rst_errors_o"}, errors_o, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check({tag, "_post_rst_s_tready"}, s_tready, 1'b1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int d0;
        int n;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tkeep  = 1'b0;
        s_tdata  = '0;
        @(posedge clock);
        #1;
        do_reset("init");

        // Clean packet 0x00..0x1F.
        rx_log.delete();
        push_ramp(32, 31);
        send_all();
        end_check("clean");
        check("clean_count", rx_log.size(), 8);
        check("clean_first_change", rx_log[0].data[15:0], 16'h0100);
        check("clean_first_ignore", rx_log[0].data[31:16], 16'h0302);
        check("clean_last_change", rx_log[7].data[15:0], 16'h1D1C);
        check("clean_last_ignore", rx_log[7].data[31:16], 16'h1F1E);
        check("clean_last_tlast", rx_log[7].last, 1'b1);

        // Output stall: sink held off for 20 cycles.
        gap_en = 1'b0;
        push_ramp(32, 31);
        fork
            send_all();
            begin
                n = 0;
                while (m_tvalid !== 1'b1 && n < 200) begin @(negedge clock); n++; end
                @(posedge clock);
                #1;
                rdy_mode = 2;
                repeat (10) @(negedge clock);
                check("stall_s_tready", s_tready, 1'b0);
                check("stall_m_tvalid", m_tvalid, 1'b1);
                repeat (10) @(negedge clock);
                @(posedge clock);
                #1;
                rdy_mode = 0;
            end
        join
        gap_en = 1'b1;
        end_check("stall");

        // Early tlast on byte 9.
        rx_log.delete();
        d0 = obs_short;
        push_ramp(10, 9);
        send_all();
        wait_drain("short");
        check("short_samples", rx_log.size(), 2);
        check("short_pulses", obs_short - d0, 1);
        @(posedge clock);
        #1;
        push_ramp(32, 31);
        send_all();
        end_check("short");

        // Missing tlast: 40 bytes, tlast only on byte 39.
        rx_log.delete();
        d0 = obs_long;
        push_ramp(40, 39);
        send_all();
        wait_drain("long");
        check("long_samples", rx_log.size(), 8);
        check("long_8th_tlast", rx_log[7].last, 1'b1);
        check("long_pulses", obs_long - d0, 1);
        @(posedge clock);
        #1;
        push_ramp(32, 31);
        send_all();
        end_check("long");

        // Null bytes between every byte.
        rx_log.delete();
        for (int i = 0; i < 32; i++) begin
            tx_q.push_back('{d: 8'(i), k: 1'b1, l: (i == 31)});
            if (i < 31) tx_q.push_back('{d: 8'($urandom), k: 1'b0, l: 1'b0});
        end
        send_all();
        end_check("null");
        check("null_count", rx_log.size(), 8);
        check("null_first_change", rx_log[0].data[15:0], 16'h0100);
        check("null_last_ignore", rx_log[7].data[31:16], 16'h1F1E);

        // Reset with a partial sample pending.
        push_ramp(6, -1);
        send_all();
        repeat (3) begin @(posedge clock); #1; end
        do_reset("partial");
        push_ramp(32, 31);
        send_all();
        end_check("after_partial");

        // Reset while a sample is held at the output.
        push_ramp(10, -1);
        send_all();
        repeat (3) begin @(posedge clock); #1; end
        rdy_mode = 2;
        repeat (2) begin @(posedge clock); #1; end
        tx_q.push_back('{d: 8'hAA, k: 1'b1, l: 1'b0});
        tx_q.push_back('{d: 8'hBB, k: 1'b1, l: 1'b0});
        send_all();
        @(negedge clock);
        check("held_before_reset", m_tvalid, 1'b1);
        @(posedge clock);
        #1;
        do_reset("held");
        rdy_mode = 0;
        push_ramp(32, 31);
        send_all();
        end_check("after_held");

        // Two consecutive samples with change field 0x1234.
        d0 = obs_change;
        for (int k = 0; k < PS; k++) begin
            tx_q.push_back('{d: (k < 2) ? 8'h34 : 8'(k), k: 1'b1, l: 1'b0});
            tx_q.push_back('{d: (k < 2) ? 8'h12 : 8'h60, k: 1'b1, l: 1'b0});
            tx_q.push_back('{d: 8'(k), k: 1'b1, l: 1'b0});
            tx_q.push_back('{d: 8'h55, k: 1'b1, l: (k == PS - 1)});
        end
        send_all();
        end_check("change");
`ifdef LOG_DECODER_CHANGE_CHECK_EN
        check("change_pulses", obs_change - d0, 1);
`else
        check("change_pulses", obs_change - d0, 0);
`endif

        // Randomized packets: random data, nulls, sink backpressure, framing faults.
        rdy_mode = 1;
        for (int p = 0; p < 8; p++) begin
            int kind = $urandom_range(0, 3);
            int len = (kind == 1) ? $urandom_range(1, 31) :
                      (kind == 2) ? 32 + $urandom_range(1, 8) : 32;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 9) == 0) tx_q.push_back('{d: 8'($urandom), k: 1'b0, l: 1'b0});
                tx_q.push_back('{d: 8'($urandom), k: 1'b1, l: (i == len - 1)});
            end
            send_all();
        end
        rdy_mode = 0;
        end_check("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
